// File: rtl/multdiv_unit.sv
// Sequential signed multiply/divide: Booth multiply and restoring divide over WIDTH-bit operands.
// Define MULTDIV_BOOTH_RADIX4_EN for radix-4 Booth multiply (WIDTH/2 iterations); default is radix-2.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int HW    = WIDTH + 2;
`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH);
`endif
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg;
  logic             r_div_ovf;
  logic             r_div_zero;
  logic             r_q1;
  logic [WIDTH-1:0] r_opm;  // multiplicand, or divisor magnitude
  logic [HW-1:0]    r_hi;   // Booth upper accumulator, or division remainder
  logic [WIDTH-1:0] r_lo;   // multiplier bits, or dividend/quotient bits

  logic             w_start;
  logic             w_start_div;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  logic [HW-1:0]    w_m_ext;
  logic [HW-1:0]    w_sum;
  logic [HW-1:0]    w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_q1;

  assign w_m_ext = {{2{r_opm[WIDTH-1]}}, r_opm};

`ifdef MULTDIV_BOOTH_RADIX4_EN
  always_comb begin
    w_sum = r_hi;
    case ({r_lo[1:0], r_q1})
      3'b001, 3'b010: w_sum = r_hi + w_m_ext;
      3'b011:         w_sum = r_hi + {w_m_ext[HW-2:0], 1'b0};
      3'b100:         w_sum = r_hi - {w_m_ext[HW-2:0], 1'b0};
      3'b101, 3'b110: w_sum = r_hi - w_m_ext;
      default:        w_sum = r_hi;
    endcase
  end

  assign w_mul_hi = {{2{w_sum[HW-1]}}, w_sum[HW-1:2]};
  assign w_mul_lo = {w_sum[1:0], r_lo[WIDTH-1:2]};
  assign w_mul_q1 = r_lo[1];
`else
  always_comb begin
    w_sum = r_hi;
    case ({r_lo[0], r_q1})
      2'b01:   w_sum = r_hi + w_m_ext;
      2'b10:   w_sum = r_hi - w_m_ext;
      default: w_sum = r_hi;
    endcase
  end

  assign w_mul_hi = {w_sum[HW-1], w_sum[HW-1:1]};
  assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};
  assign w_mul_q1 = r_lo[0];
`endif

  // Restoring divide step: shift remainder left, keep the trial subtraction when it stays non-negative
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic [HW-1:0]    w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_rem_sh = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_trial  = {1'b0, w_rem_sh} - {2'b00, r_opm};
  assign w_div_hi = w_trial[WIDTH+1] ? HW'(w_rem_sh) : HW'(w_trial[WIDTH:0]);
  assign w_div_lo = {r_lo[WIDTH-2:0], ~w_trial[WIDTH+1]};

  logic [2*WIDTH-1:0] w_prod;
  logic               w_mul_ovf;
  logic [WIDTH-1:0]   w_quot;
  logic [CNT_W-1:0]   w_last;

  assign w_prod    = {r_hi[WIDTH-1:0], r_lo};
  assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign w_quot    = r_neg ? -r_lo : r_lo;
  assign w_last    = r_is_div ? DIV_LAST : MUL_LAST;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_is_div       <= 1'b0;
      r_neg          <= 1'b0;
      r_div_ovf      <= 1'b0;
      r_div_zero     <= 1'b0;
      r_q1           <= 1'b0;
      r_opm          <= '0;
      r_hi           <= '0;
      r_lo           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (w_start) begin
      r_state        <= S_RUN;
      r_cnt          <= '0;
      r_is_div       <= w_start_div;
      r_q1           <= 1'b0;
      r_hi           <= '0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
      if (w_start_div) begin
        r_opm      <= w_b_mag;
        r_lo       <= w_a_mag;
        r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_div_zero <= (data_operandB == '0);
        r_div_ovf  <= (data_operandA == MIN_VAL) && (&data_operandB);
      end else begin
        r_opm      <= data_operandA;
        r_lo       <= data_operandB;
        r_neg      <= 1'b0;
        r_div_zero <= 1'b0;
        r_div_ovf  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (r_is_div && r_div_zero) begin
            r_state        <= S_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= '0;
            data_exception <= 1'b1;
          end else if (r_cnt == w_last) begin
            r_state        <= S_DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= r_is_div ? w_quot : r_lo;
            data_exception <= r_is_div ? r_div_ovf : w_mul_ovf;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_is_div) begin
              r_hi <= w_div_hi;
              r_lo <= w_div_lo;
            end else begin
              r_hi <= w_mul_hi;
              r_lo <= w_mul_lo;
              r_q1 <= w_mul_q1;
            end
          end
        end
        S_DONE: begin
          r_state        <= S_IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          r_state        <= S_IDLE;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule
